// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Latency: Moore outputs are combinational from state; one state transition per clock.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; no other state stalls.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur_state;
    state_t nxt_state;
    logic   retire;
    logic   illegal_hit;

    assign state = cur_state;

    // State register; reset lands in FETCH so all write enables drop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and Moore outputs; retire marks the last cycle of a legal instruction.
    always_comb begin
        nxt_state   = S_FETCH;
        iord        = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYP:      nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default: begin
                        nxt_state   = S_FETCH;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (illegal_hit) begin
            illegal_op <= 1'b1;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle vector table through a scoreboard queue,
// then hand-written asynchronous-reset sequences mid-instruction.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
module tb_multicycle_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        pc_en;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] retired;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: iord mem_req mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
    //              alu_src_b[1:0] alu_op[1:0] pc_src[1:0] pc_en
    localparam logic [14:0] O_F0   = 15'b0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [14:0] O_F1   = 15'b0_1_0_1_0_0_0_0_01_00_00_1;
    localparam logic [14:0] O_DEC  = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [14:0] O_MADR = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [14:0] O_MRD  = 15'b1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] O_MWB  = 15'b0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [14:0] O_MWR  = 15'b1_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] O_EXE  = 15'b0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [14:0] O_AWB  = 15'b0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [14:0] O_BR0  = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [14:0] O_BR1  = 15'b0_0_0_0_0_0_0_1_00_01_01_1;
    localparam logic [14:0] O_AIEX = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [14:0] O_AIWB = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [14:0] O_JMP  = 15'b0_0_0_0_0_0_0_0_00_00_10_1;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] outs;
        logic [31:0] ret;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks;
    int   n_fail;

    function automatic logic [14:0] out_word();
        return {iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, pc_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic z, input logic rdy, input logic [3:0] st,
                       input logic [14:0] outs, input logic [31:0] ret, input logic ill);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.outs = outs; v.ret = ret; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and advance to the next falling edge.
    task automatic step(input logic [5:0] op, input logic z, input logic rdy);
        opcode = op; zero = z; mem_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        vec_t e;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        // R-type with ready memory
        add(6'h3f,     0, 1, 4'd0,  O_F1,   0, 0);
        add(6'b000000, 0, 1, 4'd1,  O_DEC,  0, 0);
        add(6'h2a,     0, 1, 4'd6,  O_EXE,  0, 0);
        add(6'h15,     0, 1, 4'd7,  O_AWB,  0, 0);
        add(6'h00,     0, 0, 4'd0,  O_F0,   1, 0);
        // lw with three wait cycles; opcode scrambled where it is not sampled
        add(6'h00,     0, 1, 4'd0,  O_F1,   1, 0);
        add(6'b100011, 0, 0, 4'd1,  O_DEC,  1, 0);
        add(6'b100011, 0, 1, 4'd2,  O_MADR, 1, 0);
        add(6'h3f,     0, 0, 4'd3,  O_MRD,  1, 0);
        add(6'h2b,     0, 0, 4'd3,  O_MRD,  1, 0);
        add(6'h3f,     0, 0, 4'd3,  O_MRD,  1, 0);
        add(6'h3f,     0, 1, 4'd3,  O_MRD,  1, 0);
        add(6'h3f,     0, 0, 4'd4,  O_MWB,  1, 0);
        // sw with two wait cycles
        add(6'h00,     0, 1, 4'd0,  O_F1,   2, 0);
        add(6'b101011, 0, 0, 4'd1,  O_DEC,  2, 0);
        add(6'b101011, 0, 1, 4'd2,  O_MADR, 2, 0);
        add(6'h23,     0, 0, 4'd5,  O_MWR,  2, 0);
        add(6'h23,     0, 0, 4'd5,  O_MWR,  2, 0);
        add(6'h23,     0, 1, 4'd5,  O_MWR,  2, 0);
        // beq taken, then not taken
        add(6'h00,     0, 1, 4'd0,  O_F1,   3, 0);
        add(6'b000100, 1, 0, 4'd1,  O_DEC,  3, 0);
        add(6'h00,     1, 1, 4'd8,  O_BR1,  3, 0);
        add(6'h00,     0, 1, 4'd0,  O_F1,   4, 0);
        add(6'b000100, 1, 0, 4'd1,  O_DEC,  4, 0);
        add(6'h00,     0, 1, 4'd8,  O_BR0,  4, 0);
        // illegal opcode, then addi keeps the flag set
        add(6'h00,     0, 1, 4'd0,  O_F1,   5, 0);
        add(6'b111111, 0, 0, 4'd1,  O_DEC,  5, 0);
        add(6'h00,     0, 1, 4'd0,  O_F1,   5, 1);
        add(6'b001000, 0, 0, 4'd1,  O_DEC,  5, 1);
        add(6'h3f,     0, 1, 4'd9,  O_AIEX, 5, 1);
        add(6'h3f,     0, 1, 4'd10, O_AIWB, 5, 1);
        // jump
        add(6'h00,     0, 1, 4'd0,  O_F1,   6, 1);
        add(6'b000010, 0, 0, 4'd1,  O_DEC,  6, 1);
        add(6'h00,     0, 1, 4'd11, O_JMP,  6, 1);
        add(6'h00,     0, 0, 4'd0,  O_F0,   7, 1);

        // Reset state, mem_ready low
        #2;
        chk("reset_state",   {28'd0, state}, 32'd0);
        chk("reset_outs",    {17'd0, out_word()}, {17'd0, O_F0});
        chk("reset_retired", retired, 32'd0);
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);

        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_state", i),   {28'd0, state}, {28'd0, e.st});
            chk($sformatf("v%0d_outs", i),    {17'd0, out_word()}, {17'd0, e.outs});
            chk($sformatf("v%0d_retired", i), retired, e.ret);
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal_op}, {31'd0, e.ill});
            @(negedge clk);
        end

        // Reset asserted while in ALUWB
        step(6'h00, 0, 1);
        step(6'h00, 0, 0);
        step(6'h00, 0, 0);
        chk("aluwb_pre_state",     {28'd0, state}, 32'd7);
        chk("aluwb_pre_reg_write", {31'd0, reg_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("aluwb_rst_state",     {28'd0, state}, 32'd0);
        chk("aluwb_rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("aluwb_rst_retired",   retired, 32'd0);
        chk("aluwb_rst_illegal",   {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Illegal opcode, then reset in a stalled MEMWR
        step(6'h00,    0, 1);
        step(6'h3f,    0, 0);
        step(6'h00,    0, 1);
        step(6'b101011, 0, 0);
        step(6'b101011, 0, 0);
        step(6'h00,    0, 0);
        chk("memwr_pre_state",   {28'd0, state}, 32'd5);
        chk("memwr_pre_write",   {31'd0, mem_write}, 32'd1);
        chk("memwr_pre_illegal", {31'd0, illegal_op}, 32'd1);
        rst = 1'b1;
        #1;
        chk("memwr_rst_state",   {28'd0, state}, 32'd0);
        chk("memwr_rst_write",   {31'd0, mem_write}, 32'd0);
        chk("memwr_rst_outs",    {17'd0, out_word()}, {17'd0, O_F0});
        chk("memwr_rst_retired", retired, 32'd0);
        chk("memwr_rst_illegal", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(6'h00, 0, 0);
        chk("post_rst_state",   {28'd0, state}, 32'd0);
        chk("post_rst_retired", retired, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Moore-style main controller for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives every 2-input and 3-input 32-bit mux select in the datapath, plus register-file, IR, PC and memory write enables.
- Handles memory wait states through a ready handshake, and keeps an illegal-opcode flag and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]
zero  input  1  ALU zero flag (valid in BRANCH state)
mem_ready  input  1  memory completes the current access this cycle
iord  output  1  mem address mux: 0=PC, 1=ALUOut
mem_req  output  1  memory access active
mem_write  output  1  store strobe
ir_write  output  1  IR load enable
reg_dst  output  1  write-reg mux: 0=rt, 1=rd
mem_to_reg  output  1  write-data mux: 0=ALUOut, 1=MDR
reg_write  output  1  register-file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_src  output  2  00=ALUResult, 01=ALUOut, 10=jump target
pc_en  output  1  PC load enable
state  output  4  current state encoding (debug)
illegal_op  output  1  sticky: undefined opcode decoded
retired  output  CNT_W  instructions completed

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- On rst high (asynchronous):
  - state=FETCH, illegal_op=0, retired=0.
  - Outputs decode from FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. All other enables are 0.
  - ir_write and pc_en equal mem_ready, so they are 0 while mem_ready=0.
- Outputs are combinational from state. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - Any other value -> FETCH, set illegal_op=1 (held until rst), no write enables.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Stays while mem_ready=0, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1 held steady until mem_ready. Goes to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1. Goes to FETCH.
- retired increments by 1 on each clock edge that leaves one of MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP. It wraps from all-ones to 0. Illegal opcodes do not count.
- opcode is sampled only in DECODE and MEMADR; it may change in any other state.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- A reset asserted mid-instruction aborts it: no partial write is issued after rst rises, and retired does not count the aborted instruction.

Test Plan:
- Reset, then mem_ready=1, opcode=000000 -> states FETCH, DECODE, EXEC, ALUWB, FETCH. reg_write=1 and reg_dst=1 only in ALUWB. retired=1 after 4 cycles.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> state holds 3 at 3 cycles. MEMWB asserts mem_to_reg=1 and reg_write=1 once. Total 5+3 cycles; retired+1.
- sw (101011) with mem_ready=0 for 2 cycles -> mem_write=1 for exactly 3 cycles, iord=1 throughout, reg_write never 1.
- beq (000100) with zero=1, then repeated with zero=0 -> pc_en=1 in BRANCH only in the zero=1 case. alu_op=01 and pc_src=01 in both. 3 cycles each.
- opcode=111111 -> DECODE returns to FETCH, illegal_op=1 and stays 1 through a following addi (001000). retired does not count the illegal opcode; addi adds 1. Clears only on rst.
- Assert rst in ALUWB and in MEMWR with mem_ready=0 -> state=0 immediately (before the clock edge), reg_write=0, mem_write=0, retired=0, illegal_op=0.
